// File: rtl/array_sequencer_pkg.sv
// array_sequencer_pkg: sequencer state encoding, register offsets and register bit positions
package array_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_TMO    = 32'h08;
  localparam logic [31:0] OFF_IRQ    = 32'h0C;
  localparam logic [31:0] OFF_ENABLE = 32'h10;
  localparam int CTRL_START    = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int IRQ_DONE      = 0;
  localparam int IRQ_TIMEOUT   = 1;
endpackage

// File: rtl/array_done_tracker.sv
// array_done_tracker: sticky per-tile done flags (enabled tiles only) and their population count
module array_done_tracker
  import array_sequencer_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int CW = $clog2(NUM_TILES + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 set_en_i,
  input  logic [NUM_TILES-1:0] enable_i,
  input  logic [NUM_TILES-1:0] done_i,
  output logic [NUM_TILES-1:0] sticky_o,
  output logic [CW-1:0]        count_o
);
  logic [NUM_TILES-1:0] sticky_q, sticky_d;
  // clear wins over capture; only enabled tiles can latch done
  always_comb begin
    sticky_d = clear_i ? '0 : set_en_i ? sticky_q | (done_i & enable_i) : sticky_q;
  end
  // sticky flag register
  always_ff @(posedge clock or posedge reset)
    if (reset) sticky_q <= '0;
    else sticky_q <= sticky_d;
  // population count of latched flags
  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_TILES; i++) count_o = count_o + CW'(sticky_q[i]);
  end
  assign sticky_o = sticky_q;
endmodule

// File: rtl/array_sequencer.sv
// array_sequencer: bus-programmed start/done sequencer for a tile array; watchdog built when ARRAY_SEQUENCER_WATCHDOG_EN is defined
module array_sequencer
  import array_sequencer_pkg::*;
#(
  parameter int NUM_TILES  = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int TMO_WIDTH  = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soc_valid,
  input  logic                  soc_write,
  input  logic [ADDR_WIDTH-1:0] soc_addr,
  input  logic [31:0]           soc_wdata,
  output logic                  soc_ready,
  output logic [31:0]           soc_rdata,
  output logic                  soc_err,
  output logic [NUM_TILES-1:0]  tile_enable,
  output logic                  tile_start,
  input  logic [NUM_TILES-1:0]  tile_done,
  output logic                  irq,
  output logic                  soft_reset_out
);
  localparam int NW = (NUM_TILES + 31) / 32;
  localparam int CW = $clog2(NUM_TILES + 1);
  state_e state_q, state_d;
  logic soc_ready_q, soc_err_q, err_d, irq_q, irq_d, irq_en_q, irq_en_d, soft_rst_q, soft_rst_d;
  logic accept, start_go, tmo_hit, hit_ctrl, hit_status, hit_tmo, hit_irq, hit_en, unused_wdata;
  logic [31:0] soc_rdata_q, rdata_d, rd, en_rd, addr;
  logic [1:0] irq_stat_q, irq_stat_d, w1c, set_irq;
  logic [NUM_TILES-1:0] enable_q, enable_d, sticky;
  logic [CW-1:0] done_count;
  logic [TMO_WIDTH-1:0] tmo_rd;
  int ek;
  // address decode, register reads and write side effects for the accepted request
  always_comb begin
    addr = 32'(soc_addr);
    accept = soc_valid && !soc_ready_q;
    hit_ctrl = addr == OFF_CTRL;
    hit_status = addr == OFF_STATUS;
    hit_tmo = addr == OFF_TMO;
    hit_irq = addr == OFF_IRQ;
    hit_en = addr >= OFF_ENABLE && addr < OFF_ENABLE + 32'(4 * NW) && addr[1:0] == 2'b00;
    ek = hit_en ? int'((addr - OFF_ENABLE) >> 2) : 0;
    en_rd = '0;
    for (int i = 0; i < NUM_TILES; i++) if (i / 32 == ek) en_rd[i % 32] = enable_q[i];
    rd = '0;
    err_d = 1'b0;
    irq_en_d = irq_en_q;
    soft_rst_d = soft_rst_q;
    enable_d = enable_q;
    w1c = 2'b00;
    start_go = 1'b0;
    if (accept) begin
      if (hit_ctrl) begin
        rd = 32'({irq_en_q, soft_rst_q, 1'b0});
        if (soc_write && soc_wdata[CTRL_START] && (state_q != ST_IDLE || enable_q == '0)) err_d = 1'b1;
        else if (soc_write) begin
          irq_en_d = soc_wdata[CTRL_IRQ_EN];
          soft_rst_d = soc_wdata[CTRL_SOFT_RST];
          start_go = soc_wdata[CTRL_START];
        end
      end else if (hit_status) rd = {8'd0, 8'(done_count), 13'd0, state_q};
      else if (hit_tmo) rd = 32'(tmo_rd);
      else if (hit_irq) begin
        rd = 32'(irq_stat_q);
        w1c = soc_write ? soc_wdata[1:0] : 2'b00;
      end else if (hit_en) begin
        rd = en_rd;
        if (soc_write && state_q != ST_IDLE) err_d = 1'b1;
        else if (soc_write) for (int i = 0; i < NUM_TILES; i++) if (i / 32 == ek) enable_d[i] = soc_wdata[i % 32];
      end else err_d = 1'b1;
    end
    rdata_d = (accept && !soc_write) ? rd : '0;
  end
  // sequencing: completion beats timeout, soft reset overrides everything
  always_comb begin
    state_d = state_q;
    set_irq = 2'b00;
    case (state_q)
      ST_IDLE:  state_d = start_go ? ST_START : ST_IDLE;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        state_d = sticky == enable_q ? ST_DONE : tmo_hit ? ST_TIMEOUT : ST_RUN;
        set_irq[IRQ_DONE] = sticky == enable_q;
        set_irq[IRQ_TIMEOUT] = sticky != enable_q && tmo_hit;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (soft_rst_d) begin
      state_d = ST_IDLE;
      set_irq = 2'b00;
    end
  end
  assign irq_stat_d = (irq_stat_q & ~w1c) | set_irq;
  assign irq_d = irq_en_d && |irq_stat_d;
  assign unused_wdata = ^soc_wdata;
  // register file, bus response and state register
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      soc_ready_q <= 1'b0;
      soc_err_q <= 1'b0;
      soc_rdata_q <= '0;
      irq_en_q <= 1'b0;
      soft_rst_q <= 1'b0;
      enable_q <= '0;
      irq_stat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      soc_ready_q <= accept;
      soc_err_q <= err_d;
      soc_rdata_q <= rdata_d;
      irq_en_q <= irq_en_d;
      soft_rst_q <= soft_rst_d;
      enable_q <= enable_d;
      irq_stat_q <= irq_stat_d;
      irq_q <= irq_d;
    end
`ifdef ARRAY_SEQUENCER_WATCHDOG_EN
  logic [TMO_WIDTH-1:0] tmo_q, wdog_q;
  // watchdog limit register and RUN-cycle counter
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tmo_q <= '0;
      wdog_q <= '0;
    end else begin
      if (accept && hit_tmo && soc_write) tmo_q <= TMO_WIDTH'(soc_wdata);
      wdog_q <= (state_q == ST_START || soft_rst_d) ? '0 : state_q == ST_RUN ? wdog_q + TMO_WIDTH'(1) : wdog_q;
    end
  assign tmo_hit = tmo_q != '0 && wdog_q + TMO_WIDTH'(1) == tmo_q;
  assign tmo_rd = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo_rd = '0;
`endif
  array_done_tracker #(.NUM_TILES(NUM_TILES), .CW(CW)) u_tracker (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (state_q == ST_START || soft_rst_d),
    .set_en_i (state_q == ST_RUN),
    .enable_i (enable_q),
    .done_i   (tile_done),
    .sticky_o (sticky),
    .count_o  (done_count)
  );
  assign soc_ready = soc_ready_q;
  assign soc_rdata = soc_rdata_q;
  assign soc_err = soc_err_q;
  assign tile_enable = enable_q;
  assign tile_start = state_q == ST_START;
  assign irq = irq_q;
  assign soft_reset_out = soft_rst_q;
endmodule

// File: tb/tb_array_sequencer.sv
// tb_array_sequencer: directed bus sequences with a response scoreboard plus direct output checks
module tb_array_sequencer;
  logic clock = 1'b0, reset = 1'b1, soc_valid = 1'b0, soc_write = 1'b0;
  logic [11:0] soc_addr = '0;
  logic [31:0] soc_wdata = '0, soc_rdata;
  logic soc_ready, soc_err, tile_start, irq, soft_reset_out;
  logic [15:0] tile_enable, tile_done = '0;
  int tests = 0, fails = 0, start_pulses = 0, p;
  logic [32:0] exp_q[$];
  string name_q[$];
  always #5 clock = ~clock;
  array_sequencer dut (
    .clock(clock), .reset(reset), .soc_valid(soc_valid), .soc_write(soc_write),
    .soc_addr(soc_addr), .soc_wdata(soc_wdata), .soc_ready(soc_ready), .soc_rdata(soc_rdata),
    .soc_err(soc_err), .tile_enable(tile_enable), .tile_start(tile_start), .tile_done(tile_done),
    .irq(irq), .soft_reset_out(soft_reset_out)
  );
  always @(negedge clock) if (tile_start) start_pulses++;
  // scoreboard monitor: every response cycle pops one expectation
  always @(negedge clock) begin
    logic [32:0] e;
    string n;
    if (!reset && soc_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_response: got err=%b rdata=%h with nothing outstanding", soc_err, soc_rdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({soc_err, soc_rdata} !== e) begin
          fails++;
          $display("FAIL %s: got err=%b rdata=%h, expected err=%b rdata=%h", n, soc_err, soc_rdata, e[32], e[31:0]);
        end
      end
    end
  end
  task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d, input logic [31:0] er, input logic ee, input string nm);
    @(negedge clock);
    soc_valid = 1'b1;
    soc_write = w;
    soc_addr = a;
    soc_wdata = d;
    exp_q.push_back({ee, er});
    name_q.push_back(nm);
    @(posedge clock);
    @(negedge clock);
    soc_valid = 1'b0;
    @(posedge clock);
  endtask
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tile_enable", 32'(tile_enable), 0);
    check("rst_tile_start", 32'(tile_start), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_soft_reset_out", 32'(soft_reset_out), 0);
    check("rst_soc_ready", 32'(soc_ready), 0);
    reset = 1'b0;
    bus(0, 12'h004, 0, 32'h0, 0, "status_after_reset");
    bus(0, 12'h040, 0, 32'h0, 1, "unmapped_read");
    bus(1, 12'h040, 5, 32'h0, 1, "unmapped_write");
    bus(0, 12'h014, 0, 32'h0, 1, "enable_word1_absent");
    p = start_pulses;
    bus(1, 12'h000, 1, 32'h0, 1, "start_mask_zero");
    check("no_pulse_mask_zero", start_pulses, p);
    bus(0, 12'h004, 0, 32'h0, 0, "idle_after_mask_zero");
    bus(1, 12'h010, 32'hFFFF_000F, 32'h0, 0, "enable_write");
    bus(0, 12'h010, 0, 32'h0000_000F, 0, "enable_upper_bits_zero");
    check("tile_enable", 32'(tile_enable), 32'hF);
    p = start_pulses;
    bus(1, 12'h000, 5, 32'h0, 0, "start_write");
    check("start_single_pulse", start_pulses, p + 1);
    bus(0, 12'h004, 0, 32'h0000_0002, 0, "status_run");
    @(negedge clock) tile_done = 16'h0020;
    repeat (3) @(posedge clock);
    bus(0, 12'h004, 0, 32'h0000_0002, 0, "disabled_tile_ignored");
    @(negedge clock) tile_done = 16'h0023;
    repeat (3) @(posedge clock);
    bus(0, 12'h004, 0, 32'h0002_0002, 0, "done_count_two");
    bus(1, 12'h010, 32'hFF, 32'h0, 1, "enable_write_busy");
    bus(1, 12'h000, 5, 32'h0, 1, "start_busy");
    bus(0, 12'h010, 0, 32'h0000_000F, 0, "enable_kept");
    bus(0, 12'h000, 0, 32'h0000_0004, 0, "ctrl_readback");
    @(negedge clock) tile_done = 16'h002F;
    @(negedge clock);
    bus(0, 12'h004, 0, 32'h0004_0003, 0, "status_done_state");
    bus(0, 12'h00C, 0, 32'h0000_0001, 0, "irq_stat_done");
    bus(0, 12'h004, 0, 32'h0004_0000, 0, "idle_after_done");
    check("irq_after_done", 32'(irq), 1);
    bus(1, 12'h00C, 1, 32'h0, 0, "w1c_done");
    check("irq_after_w1c", 32'(irq), 0);
    bus(0, 12'h00C, 0, 32'h0, 0, "irq_stat_cleared");
    @(negedge clock) tile_done = 16'h0000;
    bus(1, 12'h008, 100, 32'h0, 0, "tmo_write");
`ifdef ARRAY_SEQUENCER_WATCHDOG_EN
    bus(0, 12'h008, 0, 32'd100, 0, "tmo_readback");
`else
    bus(0, 12'h008, 0, 32'd0, 0, "tmo_reads_zero");
`endif
    p = start_pulses;
    bus(1, 12'h000, 5, 32'h0, 0, "start_watchdog_run");
    check("start_pulse_2", start_pulses, p + 1);
    repeat (98) @(posedge clock);
    bus(0, 12'h004, 0, 32'h0000_0002, 0, "run_at_cycle_99");
`ifdef ARRAY_SEQUENCER_WATCHDOG_EN
    bus(0, 12'h004, 0, 32'h0000_0004, 0, "timeout_state");
    bus(0, 12'h00C, 0, 32'h0000_0002, 0, "irq_stat_timeout");
    bus(0, 12'h004, 0, 32'h0000_0000, 0, "idle_after_timeout");
    check("irq_after_timeout", 32'(irq), 1);
`else
    bus(0, 12'h004, 0, 32'h0000_0002, 0, "no_timeout_state");
    bus(0, 12'h00C, 0, 32'h0000_0000, 0, "irq_stat_no_timeout");
    @(negedge clock) tile_done = 16'h000F;
    repeat (4) @(posedge clock);
    bus(0, 12'h00C, 0, 32'h0000_0001, 0, "irq_stat_done_2");
`endif
    bus(1, 12'h00C, 3, 32'h0, 0, "w1c_all");
    check("irq_cleared", 32'(irq), 0);
    @(negedge clock) tile_done = 16'h0003;
    bus(1, 12'h000, 5, 32'h0, 0, "start_soft_run");
    repeat (2) @(posedge clock);
    bus(0, 12'h004, 0, 32'h0002_0002, 0, "soft_run_count");
    bus(1, 12'h000, 6, 32'h0, 0, "soft_rst_write");
    check("soft_reset_out_set", 32'(soft_reset_out), 1);
    bus(0, 12'h004, 0, 32'h0000_0000, 0, "status_after_soft_rst");
    bus(0, 12'h010, 0, 32'h0000_000F, 0, "enable_retained");
    bus(0, 12'h000, 0, 32'h0000_0006, 0, "ctrl_retained");
    check("tile_enable_retained", 32'(tile_enable), 32'hF);
    bus(1, 12'h000, 4, 32'h0, 0, "soft_rst_release");
    check("soft_reset_out_clear", 32'(soft_reset_out), 0);
    repeat (5) @(posedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
